// File: rtl/redmule_tile_sequencer.sv
// redmule_tile_sequencer
//   Walks the (m, k, n) tile space of one RedMulE job and issues one tile
//   descriptor per step over a valid/ready handshake. Loop order is n
//   innermost, then k, then m. Every descriptor field is a flop, so
//   tile_ready_i reaches the outputs only through registers.
//
// Optional feature: define REDMULE_TILE_SEQ_CNT_EN to enable the 32-bit
//   issued-tile counter on tile_cnt_o. Without the macro the port is tied to 0.
//
// Ports
//   clk_i, rst_ni            clock, async active-low reset
//   clear_i                  sync clear back to IDLE (highest priority)
//   start_i                  tiler config valid (sampled only in IDLE)
//   x_rows/w_cols/x_cols_iter_i    M/K/N tile counts
//   x_rows/w_cols/x_cols_lftovr_i  M/K/N leftovers (0 = none)
//   tile_valid_o/tile_ready_i      descriptor handshake
//   m/k/n_idx_o, m/k/n_last_o, m/k/n_size_o   descriptor fields
//   busy_o, done_o, tile_cnt_o     status
module redmule_tile_sequencer #(
   parameter int unsigned ARRAY_WIDTH = 12,
   parameter int unsigned N_TILE      = 16,
   parameter int unsigned K_TILE      = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic        start_i,
   input  logic [15:0] x_rows_iter_i,
   input  logic [15:0] w_cols_iter_i,
   input  logic [15:0] x_cols_iter_i,
   input  logic [7:0]  x_rows_lftovr_i,
   input  logic [7:0]  w_cols_lftovr_i,
   input  logic [7:0]  x_cols_lftovr_i,
   output logic        tile_valid_o,
   input  logic        tile_ready_i,
   output logic [15:0] m_idx_o,
   output logic [15:0] k_idx_o,
   output logic [15:0] n_idx_o,
   output logic        m_last_o,
   output logic        k_last_o,
   output logic        n_last_o,
   output logic [7:0]  m_size_o,
   output logic [7:0]  k_size_o,
   output logic [7:0]  n_size_o,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] tile_cnt_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_EMPTY = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [7:0] M_FULL = 8'(ARRAY_WIDTH);
   localparam logic [7:0] K_FULL = 8'(K_TILE);
   localparam logic [7:0] N_FULL = 8'(N_TILE);

   logic [1:0]  r_state;
   logic [15:0] r_m_max, r_k_max, r_n_max;   // count-1, latched at start
   logic [7:0]  r_m_lft, r_k_lft, r_n_lft;
   logic [15:0] r_m, r_k, r_n;
   logic        r_m_last, r_k_last, r_n_last;
   logic [7:0]  r_m_size, r_k_size, r_n_size;

   logic        w_start, w_zero, w_hs, w_final;
   logic [15:0] w_m_nxt, w_k_nxt, w_n_nxt;
   logic        w_m_last_nxt, w_k_last_nxt, w_n_last_nxt;

   function automatic logic [7:0] f_size(input logic last, input logic [7:0] lft,
                                         input logic [7:0] full);
      return (last && lft != 8'd0) ? lft : full;
   endfunction

   assign w_start = (r_state == S_IDLE) && start_i;
   assign w_zero  = (x_rows_iter_i == 16'd0) || (w_cols_iter_i == 16'd0) ||
                    (x_cols_iter_i == 16'd0);
   assign w_hs    = (r_state == S_RUN) && tile_ready_i;
   assign w_final = w_hs && r_m_last && r_k_last && r_n_last;

   // Odometer step: n wraps into k, k wraps into m.
   assign w_n_nxt = r_n_last ? 16'd0 : r_n + 16'd1;
   assign w_k_nxt = r_n_last ? (r_k_last ? 16'd0 : r_k + 16'd1) : r_k;
   assign w_m_nxt = (r_n_last && r_k_last) ? r_m + 16'd1 : r_m;
   assign w_n_last_nxt = (w_n_nxt == r_n_max);
   assign w_k_last_nxt = (w_k_nxt == r_k_max);
   assign w_m_last_nxt = (w_m_nxt == r_m_max);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= S_IDLE;
         r_m_max  <= '0; r_k_max  <= '0; r_n_max  <= '0;
         r_m_lft  <= '0; r_k_lft  <= '0; r_n_lft  <= '0;
         r_m      <= '0; r_k      <= '0; r_n      <= '0;
         r_m_last <= 1'b0; r_k_last <= 1'b0; r_n_last <= 1'b0;
         r_m_size <= '0; r_k_size <= '0; r_n_size <= '0;
      end else if (clear_i) begin
         r_state  <= S_IDLE;
         r_m_max  <= '0; r_k_max  <= '0; r_n_max  <= '0;
         r_m_lft  <= '0; r_k_lft  <= '0; r_n_lft  <= '0;
         r_m      <= '0; r_k      <= '0; r_n      <= '0;
         r_m_last <= 1'b0; r_k_last <= 1'b0; r_n_last <= 1'b0;
         r_m_size <= '0; r_k_size <= '0; r_n_size <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (start_i) begin
               if (w_zero) begin
                  r_state <= S_EMPTY;
               end else begin
                  r_state  <= S_RUN;
                  r_m_max  <= x_rows_iter_i - 16'd1;
                  r_k_max  <= w_cols_iter_i - 16'd1;
                  r_n_max  <= x_cols_iter_i - 16'd1;
                  r_m_lft  <= x_rows_lftovr_i;
                  r_k_lft  <= w_cols_lftovr_i;
                  r_n_lft  <= x_cols_lftovr_i;
                  r_m      <= '0; r_k <= '0; r_n <= '0;
                  r_m_last <= (x_rows_iter_i == 16'd1);
                  r_k_last <= (w_cols_iter_i == 16'd1);
                  r_n_last <= (x_cols_iter_i == 16'd1);
                  r_m_size <= f_size(x_rows_iter_i == 16'd1, x_rows_lftovr_i, M_FULL);
                  r_k_size <= f_size(w_cols_iter_i == 16'd1, w_cols_lftovr_i, K_FULL);
                  r_n_size <= f_size(x_cols_iter_i == 16'd1, x_cols_lftovr_i, N_FULL);
               end
            end
            S_RUN: if (w_final) begin
               r_state <= S_DONE;   // descriptor holds its final values
            end else if (w_hs) begin
               r_m      <= w_m_nxt;
               r_k      <= w_k_nxt;
               r_n      <= w_n_nxt;
               r_m_last <= w_m_last_nxt;
               r_k_last <= w_k_last_nxt;
               r_n_last <= w_n_last_nxt;
               r_m_size <= f_size(w_m_last_nxt, r_m_lft, M_FULL);
               r_k_size <= f_size(w_k_last_nxt, r_k_lft, K_FULL);
               r_n_size <= f_size(w_n_last_nxt, r_n_lft, N_FULL);
            end
            default: r_state <= S_IDLE;   // EMPTY / DONE last one cycle
         endcase
      end
   end

`ifdef REDMULE_TILE_SEQ_CNT_EN
   logic [31:0] r_cnt;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                 r_cnt <= '0;
      else if (clear_i || w_start) r_cnt <= '0;
      else if (w_hs)               r_cnt <= r_cnt + 32'd1;   // wraps mod 2^32
   end
   assign tile_cnt_o = r_cnt;
`else
   assign tile_cnt_o = 32'd0;
`endif

   // Status decodes come straight from the state flops.
   assign tile_valid_o = (r_state == S_RUN);
   assign busy_o       = (r_state != S_IDLE);
   assign done_o       = (r_state == S_EMPTY) || (r_state == S_DONE);
   assign m_idx_o      = r_m;
   assign k_idx_o      = r_k;
   assign n_idx_o      = r_n;
   assign m_last_o     = r_m_last;
   assign k_last_o     = r_k_last;
   assign n_last_o     = r_n_last;
   assign m_size_o     = r_m_size;
   assign k_size_o     = r_k_size;
   assign n_size_o     = r_n_size;

endmodule

// File: tb/tb_redmule_tile_sequencer.sv
// Directed bench for redmule_tile_sequencer: fixed jobs with hand-computed
// tile sequences, sizes, stall behaviour, clear and the optional counter.
module tb_redmule_tile_sequencer;

`ifdef REDMULE_TILE_SEQ_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        clear_i = 1'b0;
   logic        start_i = 1'b0;
   logic [15:0] x_rows_iter_i = '0, w_cols_iter_i = '0, x_cols_iter_i = '0;
   logic [7:0]  x_rows_lftovr_i = '0, w_cols_lftovr_i = '0, x_cols_lftovr_i = '0;
   logic        tile_ready_i = 1'b1;
   logic        tile_valid_o;
   logic [15:0] m_idx_o, k_idx_o, n_idx_o;
   logic        m_last_o, k_last_o, n_last_o;
   logic [7:0]  m_size_o, k_size_o, n_size_o;
   logic        busy_o, done_o;
   logic [31:0] tile_cnt_o;

   int n_cmp = 0;
   int n_err = 0;

   redmule_tile_sequencer dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
      .x_rows_iter_i(x_rows_iter_i), .w_cols_iter_i(w_cols_iter_i),
      .x_cols_iter_i(x_cols_iter_i), .x_rows_lftovr_i(x_rows_lftovr_i),
      .w_cols_lftovr_i(w_cols_lftovr_i), .x_cols_lftovr_i(x_cols_lftovr_i),
      .tile_valid_o(tile_valid_o), .tile_ready_i(tile_ready_i),
      .m_idx_o(m_idx_o), .k_idx_o(k_idx_o), .n_idx_o(n_idx_o),
      .m_last_o(m_last_o), .k_last_o(k_last_o), .n_last_o(n_last_o),
      .m_size_o(m_size_o), .k_size_o(k_size_o), .n_size_o(n_size_o),
      .busy_o(busy_o), .done_o(done_o), .tile_cnt_o(tile_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are stable 1 time unit after the edge.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic start_job(input logic [15:0] m, input logic [15:0] k, input logic [15:0] n,
                            input logic [7:0] ml, input logic [7:0] kl, input logic [7:0] nl);
      x_rows_iter_i = m; w_cols_iter_i = k; x_cols_iter_i = n;
      x_rows_lftovr_i = ml; w_cols_lftovr_i = kl; x_cols_lftovr_i = nl;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
   endtask

   task automatic chk_tile(input string tag, input int m, input int k, input int n,
                           input bit ml, input bit kl, input bit nl);
      chk({tag, ".valid"}, 32'(tile_valid_o), 32'd1);
      chk({tag, ".m"}, 32'(m_idx_o), 32'(m));
      chk({tag, ".k"}, 32'(k_idx_o), 32'(k));
      chk({tag, ".n"}, 32'(n_idx_o), 32'(n));
      chk({tag, ".lasts"}, {29'd0, m_last_o, k_last_o, n_last_o}, {29'd0, ml, kl, nl});
   endtask

   initial begin
      #12;
      // reset state
      chk("rst.valid", 32'(tile_valid_o), 0);
      chk("rst.busy", 32'(busy_o), 0);
      chk("rst.done", 32'(done_o), 0);
      chk("rst.idx", {m_idx_o, k_idx_o | n_idx_o}, 0);
      chk("rst.size", {8'd0, m_size_o, k_size_o, n_size_o}, 0);
      chk("rst.cnt", tile_cnt_o, 0);
      rst_ni = 1'b1;
      step();

      // basic 2x1x3 job, ready always high
      start_job(2, 1, 3, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         chk_tile($sformatf("basic.t%0d", i), i / 3, 0, i % 3, i >= 3, 1'b1, (i % 3) == 2);
         chk($sformatf("basic.msize%0d", i), 32'(m_size_o), 12);
         step();
      end
      chk("basic.done", 32'(done_o), 1);
      chk("basic.busy_done", 32'(busy_o), 1);
      chk("basic.valid_done", 32'(tile_valid_o), 0);
      chk("basic.cnt", tile_cnt_o, CNT_EN ? 32'd6 : 32'd0);
      step();
      chk("basic.done_off", 32'(done_o), 0);
      chk("basic.busy_off", 32'(busy_o), 0);
      chk("basic.cnt_hold", tile_cnt_o, CNT_EN ? 32'd6 : 32'd0);

      // leftovers: m=1,k=2,n=1, rows 5, cols 3
      start_job(1, 2, 1, 5, 3, 0);
      chk_tile("lft.t0", 0, 0, 0, 1'b1, 1'b0, 1'b1);
      chk("lft.t0.sizes", {8'd0, m_size_o, k_size_o, n_size_o}, {8'd0, 8'd5, 8'd16, 8'd16});
      step();
      chk_tile("lft.t1", 0, 1, 0, 1'b1, 1'b1, 1'b1);
      chk("lft.t1.sizes", {8'd0, m_size_o, k_size_o, n_size_o}, {8'd0, 8'd5, 8'd3, 8'd16});
      step();
      chk("lft.done", 32'(done_o), 1);
      step();

      // backpressure on tile 1 of a 1x1x3 job with an N leftover
      start_job(1, 1, 3, 0, 0, 7);
      chk_tile("bp.t0", 0, 0, 0, 1'b1, 1'b1, 1'b0);
      step();
      tile_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk_tile($sformatf("bp.stall%0d", i), 0, 0, 1, 1'b1, 1'b1, 1'b0);
         chk($sformatf("bp.nsize%0d", i), 32'(n_size_o), 16);
         step();
      end
      chk_tile("bp.t1", 0, 0, 1, 1'b1, 1'b1, 1'b0);
      tile_ready_i = 1'b1;
      step();
      chk_tile("bp.t2", 0, 0, 2, 1'b1, 1'b1, 1'b1);
      chk("bp.t2.nsize", 32'(n_size_o), 7);
      step();
      chk("bp.done", 32'(done_o), 1);
      chk("bp.cnt", tile_cnt_o, CNT_EN ? 32'd3 : 32'd0);
      step();

      // zero N count -> EMPTY
      start_job(2, 2, 0, 0, 0, 0);
      chk("zero.valid", 32'(tile_valid_o), 0);
      chk("zero.done", 32'(done_o), 1);
      chk("zero.busy", 32'(busy_o), 1);
      step();
      chk("zero.busy_off", 32'(busy_o), 0);
      chk("zero.done_off", 32'(done_o), 0);

      // clear during tile 2 of a 6-tile job, then restart
      start_job(2, 1, 3, 0, 0, 0);
      step();
      step();
      chk_tile("clr.t2", 0, 0, 2, 1'b0, 1'b1, 1'b1);
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
      chk("clr.valid", 32'(tile_valid_o), 0);
      chk("clr.busy", 32'(busy_o), 0);
      chk("clr.done", 32'(done_o), 0);
      chk("clr.n", 32'(n_idx_o), 0);
      chk("clr.cnt", tile_cnt_o, 0);
      step();
      chk("clr.done_late", 32'(done_o), 0);
      start_job(2, 1, 3, 0, 0, 0);
      chk_tile("clr.restart", 0, 0, 0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) step();
      chk("clr.rdone", 32'(done_o), 1);
      step();

      // 3x2x4 job: 24 tiles in odometer order
      start_job(3, 2, 4, 0, 0, 0);
      for (int i = 0; i < 24; i++) begin
         chk_tile($sformatf("big.t%0d", i), i / 8, (i / 4) % 2, i % 4,
                  (i / 8) == 2, ((i / 4) % 2) == 1, (i % 4) == 3);
         step();
      end
      chk("big.done", 32'(done_o), 1);
      chk("big.cnt", tile_cnt_o, CNT_EN ? 32'd24 : 32'd0);
      step();
      chk("big.cnt_hold", tile_cnt_o, CNT_EN ? 32'd24 : 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
